plateau_detect_fsm: RTL and testbench

PLATEAU_DETECT_FSM -- requirements
Module: plateau_detect_fsm

---
 rtl/plateau_detect_fsm_if.sv | 24 ++
 rtl/plateau_detect_fsm.sv | 170 +++++++++++++++++
 tb/tb_plateau_detect_fsm.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/plateau_detect_fsm_if.sv
// Sample-stream bus for plateau_detect_fsm: the qualified match input plus
// all registered detector outputs.
interface plateau_detect_fsm_if #(
    parameter int CNT_W = 8
);
    logic             In_Strobe;
    logic             In_Det;
    logic             Out_Strobe;
    logic             Out_Det;
    logic             Out_Det_Pulse;
    logic             Out_Timeout;
    logic [CNT_W-1:0] Out_Run_Len;
    logic [1:0]       Out_State;

    modport master (
        output In_Strobe, In_Det,
        input  Out_Strobe, Out_Det, Out_Det_Pulse, Out_Timeout, Out_Run_Len, Out_State
    );

    modport slave (
        input  In_Strobe, In_Det,
        output Out_Strobe, Out_Det, Out_Det_Pulse, Out_Timeout, Out_Run_Len, Out_State
    );
endinterface

// File: rtl/plateau_detect_fsm.sv
// Plateau detector: counts strobed matches (tolerating short miss bursts) and
// raises a detect level once the run reaches the configured length.
module plateau_detect_fsm #(
    parameter int CNT_W  = 8,
    parameter int MISS_W = 3,
    parameter int TO_W   = 12
) (
    input  logic              CLK,
    input  logic              s_RST,
    input  logic              enable,
    input  logic [CNT_W-1:0]  cfg_min_count,
    input  logic [MISS_W-1:0] cfg_max_miss,
    input  logic [TO_W-1:0]   cfg_timeout,
    input  logic              cfg_latch,
    plateau_detect_fsm_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEARCH   = 2'd1,
        ST_RUN      = 2'd2,
        ST_DETECTED = 2'd3
    } state_t;

    state_t            r_state, w_state;
    logic [CNT_W-1:0]  r_run, w_run;
    logic [MISS_W-1:0] r_miss, w_miss;
    logic [TO_W-1:0]   r_timer, w_timer;
    logic [CNT_W-1:0]  r_min, w_min;
    logic [MISS_W-1:0] r_max_miss, w_max_miss;
    logic [TO_W-1:0]   r_to, w_to;
    logic              r_latch, w_latch;
    logic              r_out_strobe, w_out_strobe;
    logic              r_det, w_det;
    logic              r_det_pulse, w_det_pulse;
    logic              r_timeout, w_timeout;

    logic              w_strobe;
    logic [CNT_W-1:0]  w_run_inc;
    logic [TO_W-1:0]   w_timer_inc;

    assign w_strobe    = bus.In_Strobe;
    assign w_run_inc   = (r_run == {CNT_W{1'b1}}) ? r_run : r_run + CNT_W'(1);
    assign w_timer_inc = r_timer + TO_W'(1);

    always_comb begin
        // NOTE: every next-value gets a default first so no path leaves one unassigned (no latches).
        w_state      = r_state;
        w_run        = r_run;
        w_miss       = r_miss;
        w_timer      = r_timer;
        w_min        = r_min;
        w_max_miss   = r_max_miss;
        w_to         = r_to;
        w_latch      = r_latch;
        w_det_pulse  = 1'b0;
        w_timeout    = 1'b0;
        w_out_strobe = enable & w_strobe;

        if (!enable) begin
            w_state    = ST_IDLE;
            w_run      = '0;
            w_miss     = '0;
            w_timer    = '0;
            w_min      = '0;
            w_max_miss = '0;
            w_to       = '0;
            w_latch    = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    // A zero run length would never match, so it is promoted to one.
                    w_min      = (cfg_min_count == '0) ? CNT_W'(1) : cfg_min_count;
                    w_max_miss = cfg_max_miss;
                    w_to       = cfg_timeout;
                    w_latch    = cfg_latch;
                    w_state    = ST_SEARCH;
                end
                ST_SEARCH: begin
                    if (w_strobe && bus.In_Det) begin
                        w_run  = CNT_W'(1);
                        w_miss = '0;
                        if (r_min == CNT_W'(1)) begin
                            w_state     = ST_DETECTED;
                            w_timer     = '0;
                            w_det_pulse = 1'b1;
                        end else begin
                            w_state = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_strobe) begin
                        if (bus.In_Det) begin
                            w_run  = w_run_inc;
                            w_miss = '0;
                            if (w_run_inc == r_min) begin
                                w_state     = ST_DETECTED;
                                w_timer     = '0;
                                w_det_pulse = 1'b1;
                            end
                        end else if (r_miss < r_max_miss) begin
                            w_miss = r_miss + MISS_W'(1);
                        end else begin
                            w_run   = '0;
                            w_miss  = '0;
                            w_state = ST_SEARCH;
                        end
                    end
                end
                ST_DETECTED: begin
                    // Zero timeout degenerates to latch mode.
                    if (w_strobe) begin
                        if (!r_latch && (r_to != '0) && (w_timer_inc == r_to)) begin
                            w_state   = ST_SEARCH;
                            w_run     = '0;
                            w_miss    = '0;
                            w_timer   = '0;
                            w_timeout = 1'b1;
                        end else begin
                            w_timer = w_timer_inc;
                        end
                    end
                end
                default: w_state = ST_IDLE;
            endcase
        end

        w_det = (w_state == ST_DETECTED);
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update together.
        if (s_RST) begin
            r_state      <= ST_IDLE;
            r_run        <= '0;
            r_miss       <= '0;
            r_timer      <= '0;
            r_min        <= '0;
            r_max_miss   <= '0;
            r_to         <= '0;
            r_latch      <= 1'b0;
            r_out_strobe <= 1'b0;
            r_det        <= 1'b0;
            r_det_pulse  <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_run        <= w_run;
            r_miss       <= w_miss;
            r_timer      <= w_timer;
            r_min        <= w_min;
            r_max_miss   <= w_max_miss;
            r_to         <= w_to;
            r_latch      <= w_latch;
            r_out_strobe <= w_out_strobe;
            r_det        <= w_det;
            r_det_pulse  <= w_det_pulse;
            r_timeout    <= w_timeout;
        end
    end

    assign bus.Out_Strobe    = r_out_strobe;
    assign bus.Out_Det       = r_det;
    assign bus.Out_Det_Pulse = r_det_pulse;
    assign bus.Out_Timeout   = r_timeout;
    assign bus.Out_Run_Len   = r_run;
    assign bus.Out_State     = r_state;

endmodule

// File: tb/tb_plateau_detect_fsm.sv
// Self-checking bench for plateau_detect_fsm: directed scenarios plus random
// traffic compared every cycle against a per-strobe reference model.
module tb_plateau_detect_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  cfg_min;
    logic [2:0]  cfg_maxm;
    logic [11:0] cfg_to;
    logic        cfg_latch;
    logic [3:0]  cfg4_min;
    logic [2:0]  cfg4_maxm;
    logic [11:0] cfg4_to;
    logic        cfg4_latch;
    logic        stb4;
    logic        det4;

    int n_checks = 0;
    int n_pass   = 0;

    plateau_detect_fsm_if #(.CNT_W(8)) if0 ();
    plateau_detect_fsm_if #(.CNT_W(4)) if4 ();

    plateau_detect_fsm #(.CNT_W(8), .MISS_W(3), .TO_W(12)) u_dut (
        .CLK           (clk),
        .s_RST         (rst),
        .enable        (en),
        .cfg_min_count (cfg_min),
        .cfg_max_miss  (cfg_maxm),
        .cfg_timeout   (cfg_to),
        .cfg_latch     (cfg_latch),
        .bus           (if0)
    );

    plateau_detect_fsm #(.CNT_W(4), .MISS_W(3), .TO_W(12)) u_dut4 (
        .CLK           (clk),
        .s_RST         (rst),
        .enable        (en),
        .cfg_min_count (cfg4_min),
        .cfg_max_miss  (cfg4_maxm),
        .cfg_timeout   (cfg4_to),
        .cfg_latch     (cfg4_latch),
        .bus           (if4)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 hunting, 2 counting, 3 detected.
    int m_phase, m_run, m_miss, m_tmr;
    int c_min, c_maxm, c_to;
    bit c_latch;
    bit e_stb, e_det, e_dp, e_to;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_step(input bit s, input bit d);
        e_dp = 1'b0;
        e_to = 1'b0;
        if (rst || !en) begin
            m_phase = 0; m_run = 0; m_miss = 0; m_tmr = 0;
            c_min = 0; c_maxm = 0; c_to = 0; c_latch = 1'b0;
            e_stb = 1'b0;
        end else begin
            e_stb = s;
            if (m_phase == 0) begin
                c_min   = (cfg_min == 0) ? 1 : int'(cfg_min);
                c_maxm  = int'(cfg_maxm);
                c_to    = int'(cfg_to);
                c_latch = cfg_latch;
                m_phase = 1;
            end else if (s) begin
                if (m_phase == 3) begin
                    m_tmr = m_tmr + 1;
                    if (!c_latch && c_to != 0 && m_tmr == c_to) begin
                        e_to = 1'b1;
                        m_phase = 1; m_run = 0; m_miss = 0; m_tmr = 0;
                    end
                end else if (d) begin
                    m_run  = (m_phase == 1) ? 1 : ((m_run + 1 > 255) ? 255 : m_run + 1);
                    m_miss = 0;
                    if (m_run == c_min) begin
                        m_phase = 3; m_tmr = 0; e_dp = 1'b1;
                    end else begin
                        m_phase = 2;
                    end
                end else if (m_phase == 2) begin
                    if (m_miss < c_maxm) m_miss = m_miss + 1;
                    else begin
                        m_run = 0; m_miss = 0; m_phase = 1;
                    end
                end
            end
        end
        e_det = (m_phase == 3);
    endtask

    task automatic step(input bit s, input bit d);
        if0.In_Strobe = s;
        if0.In_Det    = d;
        if4.In_Strobe = stb4;
        if4.In_Det    = det4;
        model_step(s, d);
        @(posedge clk);
        #1;
        check("state",   32'(if0.Out_State),     32'(m_phase));
        check("run_len", 32'(if0.Out_Run_Len),   32'(m_run));
        check("det",     32'(if0.Out_Det),       32'(e_det));
        check("det_pls", 32'(if0.Out_Det_Pulse), 32'(e_dp));
        check("timeout", 32'(if0.Out_Timeout),   32'(e_to));
        check("strobe",  32'(if0.Out_Strobe),    32'(e_stb));
        check("excl",    32'(if0.Out_Det_Pulse & if0.Out_Timeout), 32'(0));
    endtask

    task automatic rand_cfg();
        cfg_min   = 8'($urandom_range(0, 6));
        cfg_maxm  = 3'($urandom_range(0, 3));
        cfg_to    = 12'($urandom_range(0, 6));
        cfg_latch = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int n4_pulses;
        rst = 1'b1; en = 1'b0;
        cfg_min = 8'd0; cfg_maxm = 3'd0; cfg_to = 12'd0; cfg_latch = 1'b0;
        cfg4_min = 4'd0; cfg4_maxm = 3'd0; cfg4_to = 12'd0; cfg4_latch = 1'b0;
        stb4 = 1'b0; det4 = 1'b0;
        if0.In_Strobe = 1'b0; if0.In_Det = 1'b0;
        if4.In_Strobe = 1'b0; if4.In_Det = 1'b0;
        @(posedge clk); #1;

        // Reset state
        step(1, 1);
        step(0, 0);
        check("rst_state", 32'(if0.Out_State), 32'(0));
        check("rst_len",   32'(if0.Out_Run_Len), 32'(0));

        // 16 consecutive matches, no misses tolerated
        rst = 1'b0;
        cfg_min = 8'd16; cfg_maxm = 3'd0; cfg_to = 12'd0; cfg_latch = 1'b1;
        en = 1'b1;
        step(0, 0);
        for (int i = 0; i < 15; i++) step(1, 1);
        check("r22_pre_det", 32'(if0.Out_Det), 32'(0));
        step(1, 1);
        check("r22_det",   32'(if0.Out_Det), 32'(1));
        check("r22_pulse", 32'(if0.Out_Det_Pulse), 32'(1));
        check("r22_len",   32'(if0.Out_Run_Len), 32'(16));
        step(0, 0);
        check("r22_pulse_off", 32'(if0.Out_Det_Pulse), 32'(0));
        check("r22_hold",      32'(if0.Out_Det), 32'(1));

        // 10 match, 2 miss, 6 match with two misses tolerated
        en = 1'b0; step(0, 0);
        cfg_min = 8'd16; cfg_maxm = 3'd2; cfg_latch = 1'b1;
        en = 1'b1; step(0, 0);
        for (int i = 0; i < 10; i++) step(1, 1);
        step(1, 0); step(1, 0);
        for (int i = 0; i < 5; i++) step(1, 1);
        check("r23_pre_det", 32'(if0.Out_Det), 32'(0));
        step(1, 1);
        check("r23_det",   32'(if0.Out_Det), 32'(1));
        check("r23_pulse", 32'(if0.Out_Det_Pulse), 32'(1));
        check("r23_len",   32'(if0.Out_Run_Len), 32'(16));

        // Same but three misses: run abandoned
        en = 1'b0; step(0, 0);
        en = 1'b1; step(0, 0);
        for (int i = 0; i < 10; i++) step(1, 1);
        step(1, 0); step(1, 0);
        check("r23_miss2_state", 32'(if0.Out_State), 32'(2));
        check("r23_miss2_len",   32'(if0.Out_Run_Len), 32'(10));
        step(1, 0);
        check("r23_miss3_state", 32'(if0.Out_State), 32'(1));
        check("r23_miss3_len",   32'(if0.Out_Run_Len), 32'(0));

        // Auto re-arm after 5 strobes
        en = 1'b0; step(0, 0);
        cfg_min = 8'd4; cfg_maxm = 3'd0; cfg_to = 12'd5; cfg_latch = 1'b0;
        en = 1'b1; step(0, 0);
        for (int i = 0; i < 4; i++) step(1, 1);
        check("r24_det", 32'(if0.Out_Det), 32'(1));
        for (int i = 0; i < 4; i++) begin
            step(1, i[0]);
            step(0, 0);
        end
        check("r24_pre_to", 32'(if0.Out_Timeout), 32'(0));
        step(1, 0);
        check("r24_to",    32'(if0.Out_Timeout), 32'(1));
        check("r24_det0",  32'(if0.Out_Det), 32'(0));
        check("r24_state", 32'(if0.Out_State), 32'(1));
        step(0, 0);
        check("r24_to_off", 32'(if0.Out_Timeout), 32'(0));

        // Sparse strobes with In_Det held high
        en = 1'b0; step(0, 0);
        cfg_min = 8'd3; cfg_latch = 1'b1; cfg_to = 12'd0;
        en = 1'b1; step(0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 1);
            check("r25_ostb", 32'(if0.Out_Strobe), 32'(1));
            check("r25_len",  32'(if0.Out_Run_Len), 32'(k + 1));
            for (int j = 0; j < 3; j++) begin
                step(0, 1);
                check("r25_ostb0", 32'(if0.Out_Strobe), 32'(0));
                check("r25_len_hold", 32'(if0.Out_Run_Len), 32'(k + 1));
            end
        end
        check("r25_det", 32'(if0.Out_Det), 32'(1));

        // Enable dropped mid-run, new config on re-enable
        en = 1'b0; step(0, 0);
        cfg_min = 8'd20; cfg_maxm = 3'd1; cfg_latch = 1'b1;
        en = 1'b1; step(0, 0);
        for (int i = 0; i < 9; i++) step(1, 1);
        check("r26_len9", 32'(if0.Out_Run_Len), 32'(9));
        en = 1'b0; cfg_min = 8'd2;
        step(1, 1);
        check("r26_state", 32'(if0.Out_State), 32'(0));
        check("r26_len",   32'(if0.Out_Run_Len), 32'(0));
        check("r26_pulse", 32'(if0.Out_Det_Pulse | if0.Out_Timeout), 32'(0));
        en = 1'b1; step(0, 0);
        step(1, 1);
        check("r26_run1", 32'(if0.Out_Det), 32'(0));
        step(1, 1);
        check("r26_newcfg_det", 32'(if0.Out_Det), 32'(1));

        // Random traffic with random config, enable drops and resets
        for (int r = 0; r < 12; r++) begin
            en = 1'b0; rand_cfg(); step(0, 0);
            en = 1'b1;
            for (int c = 0; c < 250; c++) begin
                rst = ($urandom_range(0, 299) == 0);
                en  = ($urandom_range(0, 99) != 0);
                if ($urandom_range(0, 19) == 0) rand_cfg();
                step($urandom_range(0, 2) != 0, $urandom_range(0, 99) < 85);
            end
            rst = 1'b0;
        end

        // Narrow counter: min 15 at CNT_W=4, latched, 40 matches
        rst = 1'b1; step(0, 0);
        rst = 1'b0;
        cfg4_min = 4'd15; cfg4_maxm = 3'd0; cfg4_to = 12'd0; cfg4_latch = 1'b1;
        en = 1'b1; step(0, 0);
        stb4 = 1'b1; det4 = 1'b1;
        n4_pulses = 0;
        for (int i = 1; i <= 40; i++) begin
            step(0, 0);
            n4_pulses = n4_pulses + int'(if4.Out_Det_Pulse);
            if (i == 14) check("r27_pre_det", 32'(if4.Out_Det), 32'(0));
            if (i == 15) begin
                check("r27_det",   32'(if4.Out_Det), 32'(1));
                check("r27_pulse", 32'(if4.Out_Det_Pulse), 32'(1));
                check("r27_len",   32'(if4.Out_Run_Len), 32'(15));
            end
        end
        check("r27_hold",   32'(if4.Out_Det), 32'(1));
        check("r27_len_fz", 32'(if4.Out_Run_Len), 32'(15));
        check("r27_state",  32'(if4.Out_State), 32'(3));
        check("r27_npulse", 32'(n4_pulses), 32'(1));
        stb4 = 1'b0; det4 = 1'b0;
        rst = 1'b1;
        step(0, 0);
        check("r27_rst_det",   32'(if4.Out_Det), 32'(0));
        check("r27_rst_state", 32'(if4.Out_State), 32'(0));
        check("r27_rst_len",   32'(if4.Out_Run_Len), 32'(0));
        check("r27_rst_misc",  32'({if4.Out_Strobe, if4.Out_Det_Pulse, if4.Out_Timeout}), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
